// File: rtl/wash_pkg.sv
// wash_pkg: shared types and constants for the washer billing front end.
//   bill_state_t : billing FSM states
//   PRICE0..3    : program prices in coin units, selected by a 2-bit sel
//   COIN1/5_VAL  : credit added by each coin button
//   price_of()   : sel -> price, sat_bal() : clamp a wide result into 0..max
package wash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    RUN,
    ERR
  } bill_state_t;

  // Balance arithmetic runs one bit wider than bal so that overflow and
  // underflow are visible before clamping.
  typedef logic signed [11:0] wide_t;

  localparam int PRICE0    = 5;
  localparam int PRICE1    = 8;
  localparam int PRICE2    = 12;
  localparam int PRICE3    = 20;
  localparam int COIN1_VAL = 1;
  localparam int COIN5_VAL = 5;

  function automatic wide_t price_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return wide_t'(PRICE0);
      2'd1:    return wide_t'(PRICE1);
      2'd2:    return wide_t'(PRICE2);
      default: return wide_t'(PRICE3);
    endcase
  endfunction

  function automatic logic signed [10:0] sat_bal(input wide_t v, input int max);
    if (v > wide_t'(max)) return 11'(max);
    if (v < 0)            return '0;
    return v[10:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw pushbutton.
//   clk, rst (async, active-low)
//   btn_raw : asynchronous button input
//   level   : debounced level, follows btn_raw after DB_CYCLES stable cycles
//   pulse   : registered one-cycle pulse on each rising edge of level
module btn_debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             level_q;

  // NOTE: every flop here uses non-blocking assignment so the two-stage
  // synchronizer really is two stages; blocking would collapse it to one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= level & ~level_q;
      // Any bounce back to the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wash_billing.sv
// wash_billing: coin/purchase front end of the washer controller.
//   clk, rst (async, active-low)
//   coin1_btn, coin5_btn : raw coin buttons (+1, +5 units)
//   buy_btn, rfd_btn     : raw purchase / refund buttons
//   sel                  : program select, taken on the buy pulse
//   busy                 : washer running
//   bal                  : balance 0..BAL_MAX
//   start                : one-cycle purchase grant
//   err                  : insufficient-funds indication (ERR_CYCLES long)
//   refund, rfd_amt      : one-cycle refund pulse and the amount refunded
module wash_billing
  import wash_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DB_MS      = 20,
  parameter int DB_CYCLES  = CLK_HZ / 1000 * DB_MS,
  parameter int ERR_CYCLES = 100_000_000,
  parameter int BAL_MAX    = 999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin1_btn,
  input  logic               coin5_btn,
  input  logic               buy_btn,
  input  logic               rfd_btn,
  input  logic [1:0]         sel,
  input  logic               busy,
  output logic signed [10:0] bal,
  output logic               start,
  output logic               err,
  output logic               refund,
  output logic signed [10:0] rfd_amt
);

  localparam int ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_CYCLES - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level_unused;

  assign btn_raw = {rfd_btn, buy_btn, coin5_btn, coin1_btn};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .level  (btn_level_unused[i]),
      .pulse  (btn_pulse[i])
    );
  end

  logic coin1_p, coin5_p, buy_p, rfd_p;
  assign {rfd_p, buy_p, coin5_p, coin1_p} = btn_pulse;

  bill_state_t        state, state_next;
  logic               seen_busy;
  logic [ERR_W-1:0]   err_cnt;
  logic signed [10:0] bal_next;
  logic               do_refund;
  wide_t              credit, price, bal_ext;

  assign bal_ext = wide_t'(bal);
  assign credit  = (coin1_p ? wide_t'(COIN1_VAL) : '0)
                 + (coin5_p ? wide_t'(COIN5_VAL) : '0);
  // Price is looked up from sel in the buy-pulse cycle, which is the only
  // cycle that uses it, so the purchase is immune to later sel changes.
  assign price   = price_of(sel);

  // NOTE: every output of this block gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    bal_next   = sat_bal(bal_ext + credit, BAL_MAX);
    do_refund  = 1'b0;
    case (state)
      IDLE: begin
        // Refund beats a same-cycle buy.
        if (rfd_p) begin
          do_refund = 1'b1;
          bal_next  = sat_bal(credit, BAL_MAX);
        end else if (buy_p && !busy) begin
          if (bal_ext >= price) begin
            // Charged here so the reduced balance appears alongside start.
            state_next = CHARGE;
            bal_next   = sat_bal(bal_ext - price + credit, BAL_MAX);
          end else begin
            state_next = ERR;
          end
        end
      end
      CHARGE: state_next = RUN;
      RUN: begin
        if (!busy && seen_busy) state_next = IDLE;
      end
      ERR: begin
        if (rfd_p) begin
          do_refund  = 1'b1;
          bal_next   = sat_bal(credit, BAL_MAX);
          state_next = IDLE;
        end else if (err_cnt == ERR_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bal       <= '0;
      start     <= 1'b0;
      err       <= 1'b0;
      refund    <= 1'b0;
      rfd_amt   <= '0;
      seen_busy <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state  <= state_next;
      bal    <= bal_next;
      // Registered from the next state: start is high exactly while in
      // CHARGE, err exactly while in ERR.
      start  <= (state_next == CHARGE);
      err    <= (state_next == ERR);
      refund <= do_refund;
      if (do_refund) rfd_amt <= bal;

      if (state == CHARGE)          seen_busy <= 1'b0;
      else if (state == RUN && busy) seen_busy <= 1'b1;

      if (state == ERR && state_next == ERR) err_cnt <= err_cnt + 1'b1;
      else                                   err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wash_billing.sv
// tb_wash_billing: directed plus randomized checks of wash_billing against a
// behavioural balance model (DB_CYCLES=4, ERR_CYCLES=60).
module tb_wash_billing;

  localparam int DB   = 4;
  localparam int ERRC = 60;
  localparam int BMAX = 999;

  logic               clk = 1'b0;
  logic               rst;
  logic               coin1_btn, coin5_btn, buy_btn, rfd_btn, busy;
  logic [1:0]         sel;
  logic signed [10:0] bal, rfd_amt;
  logic               start, err, refund;

  int price_tbl [4] = '{5, 8, 12, 20};

  int errors = 0;
  int checks = 0;

  // Monitor state, sampled on the falling edge.
  int start_cnt = 0, start_wide = 0, bal_at_start = -1;
  int refund_cnt = 0, refund_wide = 0, rfd_seen = -1;
  int err_run = 0, last_err_len = 0;
  logic start_prev = 1'b0, refund_prev = 1'b0, err_prev = 1'b0;

  // Reference model: balance only; the mode is implied by the bench flow.
  int m_bal = 0;

  wash_billing #(
    .CLK_HZ    (1000),
    .DB_MS     (1),
    .DB_CYCLES (DB),
    .ERR_CYCLES(ERRC),
    .BAL_MAX   (BMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .coin1_btn(coin1_btn),
    .coin5_btn(coin5_btn),
    .buy_btn  (buy_btn),
    .rfd_btn  (rfd_btn),
    .sel      (sel),
    .busy     (busy),
    .bal      (bal),
    .start    (start),
    .err      (err),
    .refund   (refund),
    .rfd_amt  (rfd_amt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      bal_at_start = int'(bal);
      if (start_prev) start_wide++;
    end
    if (refund) begin
      refund_cnt++;
      rfd_seen = int'(rfd_amt);
      if (refund_prev) refund_wide++;
    end
    if (err) err_run++;
    else if (err_prev) begin
      last_err_len = err_run;
      err_run      = 0;
    end
    start_prev  = start;
    refund_prev = refund;
    err_prev    = err;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic c1, input logic c5, input logic b, input logic r);
    {coin1_btn, coin5_btn, buy_btn, rfd_btn} = {c1, c5, b, r};
    tick(10);
    {coin1_btn, coin5_btn, buy_btn, rfd_btn} = 4'b0;
    tick(10);
  endtask

  function automatic int sat(input int v);
    return (v > BMAX) ? BMAX : v;
  endfunction

  task automatic do_coin(input logic c1, input logic c5, input string tag);
    press(c1, c5, 1'b0, 1'b0);
    m_bal = sat(m_bal + (c1 ? 1 : 0) + (c5 ? 5 : 0));
    check(tag, int'(bal), m_bal);
  endtask

  // Buy with sel changed right after the pulse has been consumed.
  // Returns 1 when the purchase should have been granted.
  task automatic do_buy(input logic [1:0] s, input logic busy_v, output bit granted);
    int s0 = start_cnt;
    int price = price_tbl[s];
    sel     = s;
    busy    = busy_v;
    buy_btn = 1'b1;
    tick(8);
    sel = 2'($urandom_range(0, 3));
    tick(2);
    buy_btn = 1'b0;
    tick(10);
    busy = 1'b0;
    granted = !busy_v && (m_bal >= price);
    if (busy_v) begin
      check("buy_busy_nostart", start_cnt - s0, 0);
      check("buy_busy_noerr", int'(err), 0);
    end else if (granted) begin
      m_bal -= price;
      check("buy_start_once", start_cnt - s0, 1);
      check("buy_bal_at_start", bal_at_start, m_bal);
      check("buy_start_width", start_wide, 0);
    end else begin
      check("buy_err_high", int'(err), 1);
      check("buy_err_nostart", start_cnt - s0, 0);
      check("buy_err_bal", int'(bal), m_bal);
    end
  endtask

  task automatic run_busy(input int n);
    busy = 1'b1;
    tick(n);
    busy = 1'b0;
    tick(3);
  endtask

  task automatic wait_err();
    tick(ERRC);
    check("err_cleared", int'(err), 0);
    check("err_length", last_err_len, ERRC);
  endtask

  task automatic do_refund(input string tag);
    int r0 = refund_cnt;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check({tag, "_pulse"}, refund_cnt - r0, 1);
    check({tag, "_amt"}, rfd_seen, m_bal);
    m_bal = 0;
    check({tag, "_bal"}, int'(bal), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_width"}, refund_wide, 0);
  endtask

  initial begin
    bit g;
    int s0, r0;
    rst = 1'b0;
    {coin1_btn, coin5_btn, buy_btn, rfd_btn, busy} = 5'b0;
    sel = 2'd0;
    tick(3);
    check("rst_bal", int'(bal), 0);
    check("rst_start", int'(start), 0);
    check("rst_err", int'(err), 0);
    check("rst_refund", int'(refund), 0);
    check("rst_rfd_amt", int'(rfd_amt), 0);
    rst = 1'b1;
    tick(2);

    // A 2-cycle glitch never survives the debounce window.
    coin1_btn = 1'b1;
    tick(2);
    coin1_btn = 1'b0;
    tick(12);
    check("glitch_bal", int'(bal), 0);

    // Pulse lands at cycle DB+3, the balance one edge later; a long hold
    // credits exactly once.
    coin5_btn = 1'b1;
    tick(DB + 3);
    check("latency_before", int'(bal), 0);
    tick(1);
    check("latency_after", int'(bal), 5);
    tick(10);
    coin5_btn = 1'b0;
    tick(10);
    m_bal = 5;
    check("hold_once", int'(bal), 5);
    do_coin(1'b0, 1'b1, "coin5_b");
    do_coin(1'b0, 1'b1, "coin5_c");

    // Refund and buy in the same cycle: refund wins.
    s0 = start_cnt;
    r0 = refund_cnt;
    sel = 2'd0;
    press(1'b0, 1'b0, 1'b1, 1'b1);
    check("rfd_wins_pulse", refund_cnt - r0, 1);
    check("rfd_wins_amt", rfd_seen, 15);
    check("rfd_wins_nostart", start_cnt - s0, 0);
    m_bal = 0;
    check("rfd_wins_bal", int'(bal), 0);
    repeat (3) do_coin(1'b0, 1'b1, "refill");

    // 15, sel=2 -> start with bal 3; a buy during RUN is ignored.
    do_buy(2'd2, 1'b0, g);
    s0 = start_cnt;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("run_buy_ignored", start_cnt - s0, 0);
    check("run_buy_bal", int'(bal), 3);
    run_busy(10);

    // 3 < 8: error window, then again with a refund inside the window.
    do_buy(2'd1, 1'b0, g);
    wait_err();
    do_buy(2'd1, 1'b0, g);
    do_refund("err_refund");

    // Saturation at the ceiling.
    repeat (199) press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) press(1'b1, 1'b0, 1'b0, 1'b0);
    m_bal = 997;
    check("fill_997", int'(bal), 997);
    do_coin(1'b0, 1'b1, "sat_coin5");
    do_coin(1'b1, 1'b1, "sat_both");

    // Reset in RUN clears everything at once; afterwards bal=0 cannot buy.
    do_buy(2'd3, 1'b0, g);
    busy = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    check("rstrun_bal", int'(bal), 0);
    check("rstrun_start", int'(start), 0);
    check("rstrun_err", int'(err), 0);
    check("rstrun_refund", int'(refund), 0);
    check("rstrun_rfd_amt", int'(rfd_amt), 0);
    tick(2);
    busy = 1'b0;
    rst  = 1'b1;
    m_bal = 0;
    tick(2);
    do_buy(2'($urandom_range(0, 3)), 1'b0, g);
    wait_err();

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: do_coin(1'b1, 1'b0, "rnd_coin1");
        1: do_coin(1'b0, 1'b1, "rnd_coin5");
        2: do_coin(1'b1, 1'b1, "rnd_both");
        3: begin
          do_buy(2'($urandom_range(0, 3)), 1'b0, g);
          if (g) run_busy($urandom_range(1, 10));
          else if ($urandom_range(0, 1) == 0) wait_err();
          else do_refund("rnd_err_refund");
        end
        4: do_buy(2'($urandom_range(0, 3)), 1'b1, g);
        default: do_refund("rnd_refund");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
